// File: rtl/cdic_core.sv
// CD-i CDIC core: fetches HPS sectors into two buffer banks, raises a sector-ready
// interrupt and serves buffer data over the 68070 bus or single-channel DMA.
//
// fetch state | meaning
// F_IDLE      | waiting for a DBUF start
// F_REQ       | cd_hps_req high, waiting for cd_hps_ack
// F_STREAM    | storing sector words until cd_hps_ack falls
module cdic_core #(
  parameter int SECTOR_WORDS = 1176,
  parameter int NUM_BANKS    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:1] address,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic        uds,
  input  logic        lds,
  input  logic        write_strobe,
  input  logic        cs,
  output logic        bus_ack,
  output logic        intreq,
  input  logic        intack,
  output logic        req,
  input  logic        ack,
  output logic        rdy,
  input  logic        dtc,
  input  logic        done_in,
  output logic        done_out,
  output logic [31:0] cd_hps_lba,
  output logic        cd_hps_req,
  input  logic        cd_hps_ack,
  input  logic        cd_hps_data_valid,
  input  logic [15:0] cd_hps_data,
  output logic [15:0] audio_left,
  output logic [15:0] audio_right,
  output logic        fail_not_enough_words,
  output logic        fail_too_much_data
);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_STREAM} fetch_t;

  localparam int          MEM_WORDS  = SECTOR_WORDS * NUM_BANKS;
  localparam logic [10:0] SW         = 11'(SECTOR_WORDS);
  localparam logic [14:0] BANK1_BASE = 15'h1280;
  localparam logic [14:0] REG_CMD    = 15'h1E00;
  localparam logic [14:0] REG_LBA_HI = 15'h1E01;
  localparam logic [14:0] REG_LBA_LO = 15'h1E02;
  localparam logic [14:0] REG_XBUF   = 15'h1FFB;
  localparam logic [14:0] REG_DMACTL = 15'h1FFC;
  localparam logic [14:0] REG_IVEC   = 15'h1FFD;
  localparam logic [14:0] REG_DMACNT = 15'h1FFE;
  localparam logic [14:0] REG_DBUF   = 15'h1FFF;

  function automatic logic [11:0] buf_idx(input logic bank, input logic [10:0] w);
    return bank ? 12'(w) + 12'(SECTOR_WORDS) : 12'(w);
  endfunction

  logic [15:0] mem [MEM_WORDS];
  logic [15:0] buf_rd, dma_word, reg_rd, reg_val;
  logic [15:0] cmd, lba_hi, lba_lo, dma_cnt;
  logic [7:0]  ivec;
  logic        rd_is_buf, xbuf_ready, xbuf_bank, next_bank;
  logic        dma_active, dma_dir, dma_bank, dma_bank_nxt;
  logic [10:0] dma_ptr, dma_ptr_nxt, fetch_cnt;
  fetch_t      fstate;

  logic        in_region, buf_hit, buf_bank;
  logic [10:0] buf_word;
  logic [14:0] woff;

  assign woff      = address[15:1];
  assign in_region = (address[23:16] == 8'h30);

  always_comb begin
    buf_hit  = 1'b0;
    buf_bank = 1'b0;
    buf_word = '0;
    if (in_region && woff < 15'(SECTOR_WORDS)) begin
      buf_hit  = 1'b1;
      buf_word = woff[10:0];
    end else if (in_region && woff >= BANK1_BASE && woff < BANK1_BASE + 15'(SECTOR_WORDS)) begin
      buf_hit  = 1'b1;
      buf_bank = 1'b1;
      buf_word = 11'(woff - BANK1_BASE);
    end
  end

  logic host_go, host_wr, fetch_start, fetch_we, dma_start, dma_xfer;
  assign host_go     = cs & (uds | lds) & ~bus_ack;
  assign host_wr     = host_go & write_strobe;
  assign fetch_start = host_wr && in_region && woff == REG_DBUF && din[15] && cmd == 16'h002E;
  assign fetch_we    = fstate == F_STREAM && cd_hps_ack && cd_hps_data_valid && fetch_cnt < SW;
  assign dma_start   = host_wr && in_region && woff == REG_DMACTL && din[15] && dma_cnt != 16'd0;
  assign dma_xfer    = dma_active && !done_out && !done_in && ack && dtc && dma_cnt != 16'd0;

  // Prefetch follows the pointer value of the next cycle so back-to-back dtc always sees fresh data.
  always_comb begin
    dma_ptr_nxt  = dma_ptr;
    dma_bank_nxt = dma_bank;
    if (dma_start) begin
      dma_ptr_nxt  = '0;
      dma_bank_nxt = din[0];
    end else if (dma_xfer) begin
      dma_ptr_nxt = dma_ptr + 11'd1;
    end
  end

  always_comb begin
    reg_val = '0;
    if (in_region) begin
      case (woff)
        REG_CMD:    reg_val = cmd;
        REG_LBA_HI: reg_val = lba_hi;
        REG_LBA_LO: reg_val = lba_lo;
        REG_XBUF:   reg_val = {xbuf_ready, 14'b0, xbuf_bank};
        REG_DMACTL: reg_val = {dma_active, dma_dir, 13'b0, dma_bank};
        REG_IVEC:   reg_val = {8'h00, ivec};
        REG_DMACNT: reg_val = dma_cnt;
        REG_DBUF:   reg_val = {fstate != F_IDLE, 14'b0, next_bank};
        default:    reg_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fetch_we)
      mem[buf_idx(next_bank, fetch_cnt)] <= cd_hps_data;
    if (host_wr && buf_hit) begin
      if (uds) mem[buf_idx(buf_bank, buf_word)][15:8] <= din[15:8];
      if (lds) mem[buf_idx(buf_bank, buf_word)][7:0]  <= din[7:0];
    end
    if (dma_xfer && dma_dir && dma_ptr < SW)
      mem[buf_idx(dma_bank, dma_ptr)] <= din;
    if (host_go && buf_hit)
      buf_rd <= mem[buf_idx(buf_bank, buf_word)];
    if (dma_ptr_nxt < SW)
      dma_word <= mem[buf_idx(dma_bank_nxt, dma_ptr_nxt)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ack               <= 1'b0;
      rd_is_buf             <= 1'b0;
      reg_rd                <= '0;
      cmd                   <= '0;
      lba_hi                <= '0;
      lba_lo                <= '0;
      ivec                  <= '0;
      dma_cnt               <= '0;
      xbuf_ready            <= 1'b0;
      xbuf_bank             <= 1'b0;
      next_bank             <= 1'b0;
      fstate                <= F_IDLE;
      fetch_cnt             <= '0;
      cd_hps_req            <= 1'b0;
      cd_hps_lba            <= '0;
      fail_not_enough_words <= 1'b0;
      fail_too_much_data    <= 1'b0;
      dma_active            <= 1'b0;
      dma_dir               <= 1'b0;
      dma_bank              <= 1'b0;
      dma_ptr               <= '0;
      done_out              <= 1'b0;
    end else begin
      bus_ack  <= cs & (bus_ack | uds | lds);
      done_out <= 1'b0;
      if (host_go) begin
        rd_is_buf <= buf_hit;
        reg_rd    <= reg_val;
      end
      if (host_wr && in_region) begin
        case (woff)
          REG_CMD:    cmd     <= din;
          REG_LBA_HI: lba_hi  <= din;
          REG_LBA_LO: lba_lo  <= din;
          REG_IVEC:   ivec    <= din[7:0];
          REG_DMACNT: dma_cnt <= din;
          default: ;
        endcase
      end
      if (host_go && !write_strobe && in_region && woff == REG_XBUF)
        xbuf_ready <= 1'b0;

      case (fstate)
        F_IDLE:
          if (fetch_start) begin
            fstate     <= F_REQ;
            cd_hps_req <= 1'b1;
            cd_hps_lba <= {lba_hi, lba_lo};
          end
        F_REQ:
          if (cd_hps_ack) begin
            fstate     <= F_STREAM;
            cd_hps_req <= 1'b0;
            fetch_cnt  <= '0;
          end
        F_STREAM:
          if (!cd_hps_ack) begin
            fstate <= F_IDLE;
            if (fetch_cnt == SW) begin
              // completion overrides a same-cycle XBUF read-clear
              xbuf_ready <= 1'b1;
              xbuf_bank  <= next_bank;
              next_bank  <= ~next_bank;
            end else begin
              fail_not_enough_words <= 1'b1;
            end
          end else if (cd_hps_data_valid) begin
            if (fetch_cnt == SW) fail_too_much_data <= 1'b1;
            else                 fetch_cnt <= fetch_cnt + 11'd1;
          end
        default: fstate <= F_IDLE;
      endcase

      if (dma_start) begin
        dma_active <= 1'b1;
        dma_ptr    <= '0;
        dma_bank   <= din[0];
        dma_dir    <= din[14];
      end else if (done_in || done_out) begin
        dma_active <= 1'b0;
      end else if (dma_xfer) begin
        dma_ptr <= dma_ptr + 11'd1;
        dma_cnt <= dma_cnt - 16'd1;
        if (dma_cnt == 16'd1) done_out <= 1'b1;
      end
    end
  end

  always_comb begin
    if (intack)                            dout = {8'h00, ivec};
    else if (bus_ack)                      dout = rd_is_buf ? buf_rd : reg_rd;
    else if (dma_active && ack && !dma_dir) dout = dma_word;
    else                                   dout = '0;
  end

  assign intreq      = xbuf_ready;
  assign req         = dma_active;
  assign rdy         = dma_active;
  assign audio_left  = '0;
  assign audio_right = '0;

endmodule

// File: tb/tb_cdic_core.sv
// Directed bench for cdic_core: bus register/RAM access, sector fetch, interrupt, DMA and reset.
module tb_cdic_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:1] address = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        uds = 1'b0, lds = 1'b0, write_strobe = 1'b0, cs = 1'b0;
  logic        bus_ack, intreq, req, rdy, done_out;
  logic        intack = 1'b0, ack = 1'b0, dtc = 1'b0, done_in = 1'b0;
  logic [31:0] cd_hps_lba;
  logic        cd_hps_req;
  logic        cd_hps_ack = 1'b0, cd_hps_data_valid = 1'b0;
  logic [15:0] cd_hps_data = '0;
  logic [15:0] audio_left, audio_right;
  logic        fail_not_enough_words, fail_too_much_data;

  int errors = 0;
  int checks = 0;

  cdic_core dut (
    .clk(clk), .reset(reset), .address(address), .din(din), .dout(dout),
    .uds(uds), .lds(lds), .write_strobe(write_strobe), .cs(cs), .bus_ack(bus_ack),
    .intreq(intreq), .intack(intack), .req(req), .ack(ack), .rdy(rdy), .dtc(dtc),
    .done_in(done_in), .done_out(done_out), .cd_hps_lba(cd_hps_lba),
    .cd_hps_req(cd_hps_req), .cd_hps_ack(cd_hps_ack),
    .cd_hps_data_valid(cd_hps_data_valid), .cd_hps_data(cd_hps_data),
    .audio_left(audio_left), .audio_right(audio_right),
    .fail_not_enough_words(fail_not_enough_words), .fail_too_much_data(fail_too_much_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [23:0] baddr, input logic wr, input logic [15:0] data,
                     input logic u, input logic l, output logic [15:0] rd);
    int n;
    @(negedge clk);
    address = baddr[23:1]; din = data; write_strobe = wr; uds = u; lds = l; cs = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_ack && n < 4);
    check("bus_ack", bus_ack, 1);
    rd = dout;
    cs = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr16(input logic [23:0] baddr, input logic [15:0] data);
    logic [15:0] unused;
    bus(baddr, 1'b1, data, 1'b1, 1'b1, unused);
  endtask

  task automatic rd_check(input string tag, input logic [23:0] baddr, input logic [15:0] exp);
    logic [15:0] rd;
    bus(baddr, 1'b0, 16'h0000, 1'b1, 1'b1, rd);
    check(tag, rd, exp);
  endtask

  task automatic start_fetch(input logic [15:0] lba_lo);
    wr16(24'h303C02, 16'h0000);
    wr16(24'h303C04, lba_lo);
    wr16(24'h303C00, 16'h002E);
    wr16(24'h303FFE, 16'h8000);
  endtask

  task automatic stream(input int nwords, input logic [15:0] xorv, input logic [31:0] lba);
    int n = 0;
    while (!cd_hps_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hps_req", cd_hps_req, 1);
    check("hps_lba", cd_hps_lba, lba);
    cd_hps_ack = 1'b1;
    for (int k = 0; k < nwords; k++) begin
      @(negedge clk);
      cd_hps_data_valid = 1'b1;
      cd_hps_data = 16'(k) ^ xorv;
    end
    @(negedge clk);
    cd_hps_data_valid = 1'b0;
    cd_hps_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] rd;
    // reset state
    #12;
    check("rst_outputs", {bus_ack, intreq, req, rdy, done_out, cd_hps_req,
                          fail_not_enough_words, fail_too_much_data}, 0);
    check("rst_lba", cd_hps_lba, 0);
    check("rst_audio", {audio_left, audio_right}, 0);
    check("rst_dout", dout, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    wr16(24'h303FFA, 16'h0060);
    rd_check("ivec_rd", 24'h303FFA, 16'h0060);
    rd_check("unmapped_rd", 24'h303000, 16'h0000);
    check("bus_ack_drop", bus_ack, 0);

    // full sector into bank 0
    start_fetch(16'h0010);
    rd_check("dbuf_busy", 24'h303FFE, 16'h8000);
    stream(1176, 16'h0000, 32'h10);
    check("intreq_set", intreq, 1);
    check("fail_flags_ok", {fail_not_enough_words, fail_too_much_data}, 0);
    intack = 1'b1;
    #1 check("intack_vec", dout, 16'h0060);
    @(negedge clk);
    intack = 1'b0;
    rd_check("xbuf_b0", 24'h303FF6, 16'h8000);
    check("intreq_clr", intreq, 0);
    rd_check("xbuf_again", 24'h303FF6, 16'h0000);
    rd_check("dbuf_next1", 24'h303FFE, 16'h0001);
    rd_check("b0_w0", 24'h300000, 16'h0000);
    rd_check("b0_w1", 24'h300002, 16'h0001);
    rd_check("b0_w587", 24'h300000 + 24'd1174, 16'd587);
    rd_check("b0_w1175", 24'h30092E, 16'd1175);

    // second sector lands in bank 1
    start_fetch(16'h0011);
    stream(1176, 16'hA500, 32'h11);
    rd_check("xbuf_b1", 24'h303FF6, 16'h8001);
    rd_check("b1_w0", 24'h302500, 16'hA500);
    rd_check("b1_w1175", 24'h302E2E, 16'hA197);
    rd_check("b0_w3_kept", 24'h300006, 16'h0003);

    // short sector: abort, no interrupt, bank unchanged
    start_fetch(16'h0012);
    stream(1000, 16'h5500, 32'h12);
    check("fail_short", fail_not_enough_words, 1);
    check("intreq_short", intreq, 0);
    rd_check("dbuf_after_abort", 24'h303FFE, 16'h0000);

    // overlong sector: extra word discarded
    start_fetch(16'h0013);
    stream(1177, 16'h0000, 32'h13);
    check("fail_long", fail_too_much_data, 1);
    check("intreq_long", intreq, 1);
    rd_check("xbuf_long", 24'h303FF6, 16'h8000);
    rd_check("b0_w1175_intact", 24'h30092E, 16'd1175);
    rd_check("b0_w5_rewritten", 24'h30000A, 16'h0005);

    // DMA read of 4 words from bank 0
    wr16(24'h303FFC, 16'd4);
    wr16(24'h303FF8, 16'h8000);
    check("dma_req_rdy", {req, rdy}, 2'b11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack = 1'b1; dtc = 1'b1;
      #1 check($sformatf("dma_rd_w%0d", i), dout, 16'(i));
    end
    @(negedge clk);
    ack = 1'b0; dtc = 1'b0;
    check("done_pulse", {done_out, req}, 2'b11);
    @(negedge clk);
    check("done_end", {done_out, req, rdy}, 3'b000);
    rd_check("dmacnt_zero", 24'h303FFC, 16'h0000);

    // DMA write of 2 words into bank 1
    wr16(24'h303FFC, 16'd2);
    wr16(24'h303FF8, 16'hC001);
    @(negedge clk);
    ack = 1'b1; dtc = 1'b1; din = 16'h1234;
    @(negedge clk);
    din = 16'h5678;
    @(negedge clk);
    ack = 1'b0; dtc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("dma_wr_idle", req, 0);
    rd_check("dma_wr_w0", 24'h302500, 16'h1234);
    rd_check("dma_wr_w1", 24'h302502, 16'h5678);

    // DMA terminated by done_in after 2 words
    wr16(24'h303FFC, 16'd4);
    wr16(24'h303FF8, 16'h8000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ack = 1'b1; dtc = 1'b1;
      #1 check($sformatf("dma_abort_w%0d", i), dout, 16'(i));
    end
    @(negedge clk);
    ack = 1'b0; dtc = 1'b0; done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    check("done_in_stop", {req, rdy, done_out}, 3'b000);
    @(negedge clk);
    check("done_in_no_pulse", done_out, 0);
    rd_check("dmacnt_left", 24'h303FFC, 16'd2);

    // byte-lane writes
    bus(24'h300000, 1'b1, 16'hABCD, 1'b0, 1'b1, rd);
    rd_check("lds_only", 24'h300000, 16'h00CD);
    bus(24'h300000, 1'b1, 16'h12EF, 1'b1, 1'b0, rd);
    rd_check("uds_only", 24'h300000, 16'h12CD);

    // async reset in the middle of a sector
    start_fetch(16'h0014);
    @(negedge clk);
    cd_hps_ack = 1'b1;
    repeat (10) begin
      @(negedge clk);
      cd_hps_data_valid = 1'b1;
    end
    #2 reset = 1'b1;
    #1;
    check("rst_mid_outputs", {bus_ack, intreq, req, rdy, done_out, cd_hps_req,
                              fail_not_enough_words, fail_too_much_data}, 0);
    check("rst_mid_lba", cd_hps_lba, 0);
    check("rst_mid_dout", dout, 0);
    cd_hps_data_valid = 1'b0;
    cd_hps_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd_check("dbuf_after_reset", 24'h303FFE, 16'h0000);
    check("fails_after_reset", {fail_not_enough_words, fail_too_much_data}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
